// File: rtl/dm_banked_sync.sv
// Banked MEM-stage data memory: byte/half/word stores with lane merge, extended sub-word loads,
// registered 1-cycle read, range/alignment exceptions, store trace port and a hardware clear sweep.
`timescale 1ns/1ps
module dm_banked_sync #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmReq,
    input  logic        dmWriteEn,
    input  logic [2:0]  dmOp,
    input  logic [31:0] dmMemAddr,
    input  logic [31:0] dmWD,
    output logic        dmBusy,
    output logic        dmRdValid,
    output logic [31:0] dmRD,
    output logic [1:0]  dmExc,
    output logic        stLogValid,
    output logic [31:0] stLogAddr,
    output logic [31:0] stLogData
);
    localparam int                    DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [32:0]           LIMIT    = 33'd4 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] LAST_IDX = {DEPTH_LOG2{1'b1}};

    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_HU = 3'b010;
    localparam logic [2:0] OP_B  = 3'b011;
    localparam logic [2:0] OP_BU = 3'b100;

    localparam logic [1:0] EXC_NONE  = 2'b00;
    localparam logic [1:0] EXC_ALIGN = 2'b01;
    localparam logic [1:0] EXC_RANGE = 2'b10;

    typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

    state_t                state;
    state_t                stateNext;
    logic [DEPTH_LOG2-1:0] clrIdx;
    logic [31:0]           mem [DEPTH];

    logic [31:0]           offset;
    logic                  outRange;
    logic                  misalign;
    logic [1:0]            excCode;
    logic [DEPTH_LOG2-1:0] wordIdx;
    logic [1:0]            lane;
    logic [3:0]            byteEn;
    logic [31:0]           wrData;
    logic [31:0]           oldWord;
    logic [31:0]           merged;
    logic [31:0]           loadData;
    logic                  accept;
    logic                  storeCommit;

    // Replace the enabled byte lanes of a stored word with the new data.
    function automatic logic [31:0] mergeLanes(input logic [31:0] oldW, input logic [31:0] newW,
                                               input logic [3:0] be);
        logic [31:0] res;
        res = oldW;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? newW[8*i +: 8] : oldW[8*i +: 8];
        end
        return res;
    endfunction

    // Select the addressed lane(s) and sign- or zero-extend according to the load type.
    function automatic logic [31:0] extractLoad(input logic [31:0] word, input logic [1:0] ln,
                                                input logic [2:0] op);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {ln, 3'b000};
        case (op)
            OP_B:    res = {{24{sh[7]}}, sh[7:0]};
            OP_BU:   res = {24'h00_0000, sh[7:0]};
            OP_H:    res = {{16{sh[15]}}, sh[15:0]};
            OP_HU:   res = {16'h0000, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Address decode, exception priority (range before alignment) and store lane enables.
    always_comb begin
        offset   = dmMemAddr - BASE_ADDR;
        outRange = (dmMemAddr < BASE_ADDR) | ({1'b0, offset} >= LIMIT);
        wordIdx  = offset[DEPTH_LOG2+1:2];
        lane     = dmMemAddr[1:0];
        misalign = 1'b0;
        byteEn   = 4'b1111;
        wrData   = dmWD;
        case (dmOp)
            OP_B, OP_BU: begin
                misalign = 1'b0;
                byteEn   = 4'b0001 << lane;
                wrData   = {4{dmWD[7:0]}};
            end
            OP_H, OP_HU: begin
                misalign = lane[0];
                byteEn   = 4'b0011 << lane;
                wrData   = {2{dmWD[15:0]}};
            end
            default: begin
                misalign = (lane != 2'b00);
                byteEn   = 4'b1111;
                wrData   = dmWD;
            end
        endcase
        excCode = outRange ? EXC_RANGE : (misalign ? EXC_ALIGN : EXC_NONE);
    end

    // Read-modify-write path for stores and the extended view for loads.
    always_comb begin
        oldWord     = mem[wordIdx];
        merged      = mergeLanes(oldWord, wrData, byteEn);
        loadData    = extractLoad(oldWord, lane, dmOp);
        accept      = dmReq & ~dmBusy;
        storeCommit = accept & dmWriteEn & (excCode == EXC_NONE) & ~reset;
    end

    // State register and clear-sweep index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_CLEAR;
            clrIdx <= '0;
        end else begin
            state  <= stateNext;
            clrIdx <= (state == ST_CLEAR) ? clrIdx + DEPTH_LOG2'(1) : clrIdx;
        end
    end

    // Next-state: leave CLEAR once the last word has been zeroed.
    always_comb begin
        stateNext = state;
        case (state)
            ST_CLEAR: stateNext = (clrIdx == LAST_IDX) ? ST_IDLE : ST_CLEAR;
            ST_IDLE:  stateNext = ST_IDLE;
            default:  stateNext = ST_CLEAR;
        endcase
    end

    // Busy flag is a direct decode of the state.
    always_comb begin
        dmBusy = 1'b0;
        case (state)
            ST_CLEAR: dmBusy = 1'b1;
            ST_IDLE:  dmBusy = 1'b0;
            default:  dmBusy = 1'b1;
        endcase
    end

    // Memory array: one word zeroed per sweep cycle, otherwise committed stores.
    always_ff @(posedge clk) begin
        if ((state == ST_CLEAR) && !reset) begin
            mem[clrIdx] <= 32'h0000_0000;
        end else if (storeCommit) begin
            mem[wordIdx] <= merged;
        end
    end

    // Registered result and trace outputs; data holds until the next accept of its kind.
    always_ff @(posedge clk) begin
        if (reset) begin
            dmRdValid  <= 1'b0;
            dmRD       <= 32'h0000_0000;
            dmExc      <= EXC_NONE;
            stLogValid <= 1'b0;
            stLogAddr  <= 32'h0000_0000;
            stLogData  <= 32'h0000_0000;
        end else begin
            dmRdValid  <= accept & ~dmWriteEn;
            stLogValid <= accept & dmWriteEn;
            dmExc      <= accept ? excCode : EXC_NONE;
            if (accept && !dmWriteEn) begin
                dmRD <= (excCode == EXC_NONE) ? loadData : 32'h0000_0000;
            end
            if (accept && dmWriteEn) begin
                stLogAddr <= dmMemAddr;
                stLogData <= (excCode == EXC_NONE) ? merged : 32'h0000_0000;
            end
        end
    end
endmodule

// File: tb/tb_dm_banked_sync.sv
// Scoreboard bench for dm_banked_sync: instance A at base 0, instance B at base 0x1000, both 16 words.
`timescale 1ns/1ps
module tb_dm_banked_sync;
    localparam logic [2:0] W  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] HU = 3'b010;
    localparam logic [2:0] B  = 3'b011;
    localparam logic [2:0] BU = 3'b100;

    typedef struct {
        bit          isStore;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  exc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        aReset, aReq, aWe, bReset, bReq, bWe;
    logic [2:0]  aOp, bOp;
    logic [31:0] aAddr, aWD, bAddr, bWD;
    logic        aBusy, aRdValid, aStValid, bBusy, bRdValid, bStValid;
    logic [31:0] aRD, aStAddr, aStData, bRD, bStAddr, bStData;
    logic [1:0]  aExc, bExc;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   passed = 0;

    dm_banked_sync #(.DEPTH_LOG2(4), .BASE_ADDR(32'h0000_0000)) dutA (
        .clk(clk), .reset(aReset), .dmReq(aReq), .dmWriteEn(aWe), .dmOp(aOp),
        .dmMemAddr(aAddr), .dmWD(aWD), .dmBusy(aBusy), .dmRdValid(aRdValid), .dmRD(aRD),
        .dmExc(aExc), .stLogValid(aStValid), .stLogAddr(aStAddr), .stLogData(aStData));

    dm_banked_sync #(.DEPTH_LOG2(4), .BASE_ADDR(32'h0000_1000)) dutB (
        .clk(clk), .reset(bReset), .dmReq(bReq), .dmWriteEn(bWe), .dmOp(bOp),
        .dmMemAddr(bAddr), .dmWD(bWD), .dmBusy(bBusy), .dmRdValid(bRdValid), .dmRD(bRD),
        .dmExc(bExc), .stLogValid(bStValid), .stLogAddr(bStAddr), .stLogData(bStData));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Pops one expectation per result pulse; exc must be 00 whenever no pulse is present.
    task automatic monitor(input bit inst, input logic rdV, input logic stV, input logic [31:0] rd,
                           input logic [31:0] stA, input logic [31:0] stD, input logic [1:0] exc);
        exp_t e;
        if (rdV || stV) begin
            if ((inst ? qb.size() : qa.size()) == 0) begin
                checks++;
                $display("FAIL unexpected_pulse inst%0d: got rdValid=%b stLogValid=%b, expected none",
                         inst, rdV, stV);
            end else begin
                e = inst ? qb.pop_front() : qa.pop_front();
                check("pulse_kind", {30'b0, rdV, stV}, {30'b0, ~e.isStore, e.isStore});
                if (e.isStore) begin
                    check("stLogAddr", stA, e.addr);
                    check("stLogData", stD, e.data);
                end else begin
                    check("dmRD", rd, e.data);
                end
                check("dmExc", {30'b0, exc}, {30'b0, e.exc});
            end
        end else begin
            check("dmExc_idle", {30'b0, exc}, 32'h0);
        end
    endtask

    always @(negedge clk) monitor(1'b0, aRdValid, aStValid, aRD, aStAddr, aStData, aExc);
    always @(negedge clk) monitor(1'b1, bRdValid, bStValid, bRD, bStAddr, bStData, bExc);

    task automatic issue(input bit inst, input bit we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] expData, input logic [1:0] expExc);
        exp_t e;
        e.isStore = we;
        e.addr    = addr;
        e.data    = expData;
        e.exc     = expExc;
        if (inst) begin
            bReq = 1'b1; bWe = we; bOp = op; bAddr = addr; bWD = wd;
            qb.push_back(e);
        end else begin
            aReq = 1'b1; aWe = we; aOp = op; aAddr = addr; aWD = wd;
            qa.push_back(e);
        end
        @(posedge clk);
        #1;
        aReq = 1'b0;
        bReq = 1'b0;
    endtask

    // One-cycle reset, then count busy cycles (optionally with a request held that must be ignored).
    task automatic doReset(input bit inst, input bit holdReq, input string name);
        int cnt;
        cnt = 0;
        if (inst) bReset = 1'b1; else aReset = 1'b1;
        @(posedge clk);
        #1;
        aReset = 1'b0;
        bReset = 1'b0;
        if (holdReq) begin
            aReq = 1'b1; aWe = 1'b1; aOp = W; aAddr = 32'h0; aWD = 32'hFFFF_FFFF;
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (inst ? bBusy : aBusy) cnt++;
            else break;
        end
        aReq = 1'b0;
        check(name, 32'(cnt), 32'd16);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        aReset = 1'b1; aReq = 1'b0; aWe = 1'b0; aOp = W; aAddr = 32'h0; aWD = 32'h0;
        bReset = 1'b1; bReq = 1'b0; bWe = 1'b0; bOp = W; bAddr = 32'h0; bWD = 32'h0;
        @(posedge clk);
        #1;
        // Sweep with a held store that must be ignored, then every word reads back zero.
        doReset(1'b0, 1'b1, "sweep_busy_a");
        for (int i = 0; i < 16; i++) issue(1'b0, 1'b0, W, 32'(i * 4), 32'h0, 32'h0, 2'b00);

        // Word store then byte merge.
        issue(1'b0, 1'b1, W,  32'h8, 32'h1122_3344, 32'h1122_3344, 2'b00);
        issue(1'b0, 1'b1, B,  32'h9, 32'h0000_00AB, 32'h1122_AB44, 2'b00);
        issue(1'b0, 1'b0, W,  32'h8, 32'h0, 32'h1122_AB44, 2'b00);
        issue(1'b0, 1'b0, B,  32'h9, 32'h0, 32'hFFFF_FFAB, 2'b00);
        issue(1'b0, 1'b0, 3'b111, 32'h8, 32'h0, 32'h1122_AB44, 2'b00);

        // Half store and signed/unsigned sub-word loads.
        issue(1'b0, 1'b1, H,  32'h4, 32'h0000_8001, 32'h0000_8001, 2'b00);
        issue(1'b0, 1'b0, H,  32'h4, 32'h0, 32'hFFFF_8001, 2'b00);
        issue(1'b0, 1'b0, HU, 32'h4, 32'h0, 32'h0000_8001, 2'b00);
        issue(1'b0, 1'b0, B,  32'h5, 32'h0, 32'hFFFF_FF80, 2'b00);
        issue(1'b0, 1'b0, BU, 32'h4, 32'h0, 32'h0000_0001, 2'b00);
        issue(1'b0, 1'b1, H,  32'h6, 32'h0000_1234, 32'h1234_8001, 2'b00);
        issue(1'b0, 1'b0, HU, 32'h6, 32'h0, 32'h0000_1234, 2'b00);

        // Exceptions and range boundary.
        issue(1'b0, 1'b0, W,  32'h6,  32'h0, 32'h0, 2'b01);
        issue(1'b0, 1'b1, H,  32'h3,  32'h0000_FFFF, 32'h0, 2'b01);
        issue(1'b0, 1'b0, W,  32'h0,  32'h0, 32'h0, 2'b00);
        issue(1'b0, 1'b0, W,  32'h40, 32'h0, 32'h0, 2'b10);
        issue(1'b0, 1'b1, B,  32'h40, 32'h0000_00EE, 32'h0, 2'b10);
        issue(1'b0, 1'b0, W,  32'h41, 32'h0, 32'h0, 2'b10);
        issue(1'b0, 1'b0, BU, 32'h3F, 32'h0, 32'h0, 2'b00);
        issue(1'b0, 1'b1, W,  32'h3C, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00);
        issue(1'b0, 1'b0, W,  32'h3C, 32'h0, 32'hDEAD_BEEF, 2'b00);
        issue(1'b0, 1'b0, W,  32'h0,  32'h0, 32'h0, 2'b00);

        // Back-to-back store then two loads of the same word.
        issue(1'b0, 1'b1, W, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 2'b00);
        issue(1'b0, 1'b0, W, 32'h0, 32'h0, 32'hCAFE_F00D, 2'b00);
        issue(1'b0, 1'b0, W, 32'h0, 32'h0, 32'hCAFE_F00D, 2'b00);
        repeat (2) @(posedge clk);
        #1;

        // Non-zero base address instance.
        doReset(1'b1, 1'b0, "sweep_busy_b");
        issue(1'b1, 1'b1, W, 32'h1004, 32'h5A5A_0001, 32'h5A5A_0001, 2'b00);
        issue(1'b1, 1'b0, W, 32'h1004, 32'h0, 32'h5A5A_0001, 2'b00);
        issue(1'b1, 1'b0, W, 32'h0FFC, 32'h0, 32'h0, 2'b10);
        issue(1'b1, 1'b0, W, 32'h1000, 32'h0, 32'h0, 2'b00);
        issue(1'b1, 1'b0, W, 32'h1040, 32'h0, 32'h0, 2'b10);

        // Reset again part-way through the sweep: busy must restart for a full 16 cycles.
        bReset = 1'b1;
        @(posedge clk);
        #1;
        bReset = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("busy_mid_sweep", {31'b0, bBusy}, 32'd1);
        doReset(1'b1, 1'b0, "sweep_restart_b");
        issue(1'b1, 1'b0, W, 32'h1004, 32'h0, 32'h0, 2'b00);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drain", 32'(qa.size() + qb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
